fir_out_decimator: RTL
======================

// Module: fir_out_decimator
// PURPOSE
//  Output stage directly downstream of the FIR filter. Accepts the wide signed FIR result yn,
//  rounds it (round-half-up, arithmetic shift), saturates it to DATA_WIDTH, and keeps 1 of every DECIM samples.
//  Buffers kept samples in a small FIFO with a valid/ready handshake to the consumer.
// PARAMETERS
//  DATA_WIDTH  16                 output sample width, signed
//  IN_WIDTH    2*DATA_WIDTH+2     width of FIR output yn, signed
//  SHIFT       4                  right-shift applied before saturation (0 = no shift, no rounding)
//  DECIM       2                  decimation factor, >=1 (1 = keep every sample)
//  FIFO_DEPTH  4                  output FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               synchronous, active-high reset
//  start      in   1               1-cycle pulse: restart decimation phase, clear FIFO and sticky flags
//  in_valid   in   1               yn_in holds a valid FIR result this cycle
//  yn_in      in   IN_WIDTH        signed FIR output
//  out_data   out  DATA_WIDTH      signed head-of-FIFO sample
//  out_valid  out  1               FIFO non-empty
//  out_ready  in   1               consumer accepts out_data when out_valid&&out_ready
//  fifo_count out  clog2(DEPTH)+1  current FIFO occupancy
//  sat_flag   out  1               sticky: any kept sample was clipped
//  overflow   out  1               sticky: a kept sample was dropped because FIFO was full
// BEHAVIOUR
//  Reset (rst=1 at edge): phase=0, stage reg invalid, FIFO empty, out_data=0, out_valid=0,
//   fifo_count=0, sat_flag=0, overflow=0. rst has priority over start and all other inputs.
//  start=1 (no rst): same clearing as reset. Any in_valid in that cycle is discarded.
//  Decimation: phase counter 0..DECIM-1, advances on each accepted in_valid and wraps to 0.
//   Sample kept iff phase==0 at acceptance, so kept samples are the 1st, (DECIM+1)th, ... after reset/start.
//  Arithmetic (stage 1, registered):
//   t = sign-extend yn_in to IN_WIDTH+1 bits + (SHIFT>0 ? 1<<(SHIFT-1) : 0).
//   r = t >>> SHIFT (arithmetic).
//   If r > 2^(DATA_WIDTH-1)-1, result = max. If r < -2^(DATA_WIDTH-1), result = min. Else result = r.
//   A clipped result sets sat_flag.
//   Stage reg captures result and s1_valid = (in_valid && phase==0).
//  FIFO push (stage 2): when s1_valid, the result is written the next edge.
//   If the FIFO is full and no pop occurs that cycle, the sample is dropped and overflow is set. FIFO is unchanged.
//   If the FIFO is full and a pop occurs the same cycle, the push succeeds. Count stays at DEPTH.
//  Pop: on out_valid&&out_ready, the head advances. Pop when empty is impossible (out_valid=0).
//  Simultaneous push+pop (not full): count unchanged, order preserved.
//  FIFO is first-word fall-through. out_data is the head entry, or 0 when empty.
//  Latency: a kept in_valid sampled at edge N gives out_valid=1 after edge N+1 when the FIFO was empty.
//   Read and write pointers wrap modulo FIFO_DEPTH. count is exact, 0..DEPTH.
//  Throughput: one input per cycle. Output stream is stalled only by out_ready.
//  Sticky flags clear only on rst or start.
// TESTING
//  T1 round/scale: SHIFT=4, DECIM=1. yn_in=40 -> out 3; yn_in=-40 -> out -2; yn_in=8 -> out 1; sat_flag stays 0.
//  T2 saturate: yn_in=2^20 -> out 32767, sat_flag=1. yn_in=-2^20 -> out -32768.
//  T3 decimate: DECIM=2, inputs 16,32,48,64 (shift 4) -> outputs 1,3 only. Pulse start, then input 80 -> output 5 (phase reset).
//  T4 latency: empty FIFO, kept sample at edge N -> out_valid=1 after edge N+1, out_data correct; out_ready=1 -> empty next edge.
//  T5 full/backpressure: out_ready=0, DECIM=1, feed 6 samples -> fifo_count=4, overflow=1, first 4 emerge in order.
//   Full + push + pop in same cycle -> count stays 4, no overflow.
//  T6 reset mid-stream: rst during FIFO=3 with out_ready=0 -> next cycle out_valid=0, count=0, flags=0, phase=0.

Source files
------------

// File: rtl/fir_out_decimator_if.sv
// Stream bundle between the FIR output stage and its neighbours: control and
// sample inputs, buffered decimated output with valid/ready, and status.
interface fir_out_decimator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_WIDTH   = 2 * DATA_WIDTH + 2,
    parameter int FIFO_DEPTH = 4
);
    logic                          start;
    logic                          in_valid;
    logic [IN_WIDTH-1:0]           yn_in;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          sat_flag;
    logic                          overflow;

    modport master (
        output start, in_valid, yn_in, out_ready,
        input  out_data, out_valid, fifo_count, sat_flag, overflow
    );

    modport slave (
        input  start, in_valid, yn_in, out_ready,
        output out_data, out_valid, fifo_count, sat_flag, overflow
    );
endinterface

// File: rtl/fir_out_decimator.sv
// FIR output stage: round-half-up shift, saturate to DATA_WIDTH, keep 1 of DECIM
// samples, and buffer kept samples in a first-word-fall-through FIFO.
module fir_out_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_WIDTH   = 2 * DATA_WIDTH + 2,
    parameter int SHIFT      = 4,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    fir_out_decimator_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [IN_WIDTH:0] ROUND =
        (SHIFT > 0) ? ((IN_WIDTH + 1)'(1) << (SHIFT - 1)) : '0;
    localparam logic signed [IN_WIDTH:0] MAXV =
        {{(IN_WIDTH - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MINV =
        {{(IN_WIDTH - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] DMAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] DMIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    logic                      clear;
    logic [PW-1:0]             phase;
    logic                      take;
    logic signed [IN_WIDTH:0]  t_sum;
    logic signed [IN_WIDTH:0]  r_shift;
    logic                      clip;
    logic [DATA_WIDTH-1:0]     result;
    logic                      s1_valid;
    logic [DATA_WIDTH-1:0]     s1_data;
    logic                      sat_q;
    logic                      ovf_q;

    logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [CW-1:0]             count;
    logic                      full;
    logic                      pop;
    logic                      push;

    assign clear = rst || bus.start;
    assign take  = bus.in_valid && (phase == '0);

    // One extra bit of headroom so the rounding offset can never wrap the sum.
    always_comb begin
        t_sum   = $signed({bus.yn_in[IN_WIDTH-1], bus.yn_in}) + ROUND;
        r_shift = t_sum >>> SHIFT;
        clip    = 1'b0;
        result  = r_shift[DATA_WIDTH-1:0];
        if (r_shift > MAXV) begin
            result = DMAX;
            clip   = 1'b1;
        end else if (r_shift < MINV) begin
            result = DMIN;
            clip   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            phase    <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            sat_q    <= 1'b0;
        end else begin
            s1_valid <= take;
            if (take) begin
                s1_data <= result;
                if (clip) begin
                    sat_q <= 1'b1;
                end
            end
            if (bus.in_valid) begin
                phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
            end
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign full = (count == CW'(FIFO_DEPTH));
    assign pop  = (count != '0) && bus.out_ready;
    assign push = s1_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
            if (s1_valid && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= s1_data;
        end
    end

    assign bus.out_data   = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.out_valid  = (count != '0);
    assign bus.fifo_count = count;
    assign bus.sat_flag   = sat_q;
    assign bus.overflow   = ovf_q;
endmodule
